// File: rtl/rgb_pwm.sv
// ---------------------------------------------------------------------------
// rgb_pwm
//
// Three-channel PWM generator for the RGB LED pins of the colour-cycling
// design. Duty triples arrive from the hue generator over a valid/ready
// handshake. Each accepted triple waits in a one-entry pending buffer.
// It is applied only at a PWM period boundary, so a colour change never
// tears a period.
//
// Period length is 2^PWM_BITS * PRESCALE clocks.
//
// Parameters:
//   PWM_BITS     duty and counter width (default 8)
//   PRESCALE     clocks per PWM count, must be >= 1 (default 48)
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset
//   duty_valid   a duty triple is offered
//   duty_ready   pending buffer empty; an offered triple is accepted
//   duty_r/g/b   on-time in counts, 0 .. 2^PWM_BITS-1
//   period_start one-clock pulse in the first cycle of each new period
//   pwm_r/g/b    registered PWM outputs
//
// Build option:
//   RGB_PWM_ACTIVE_LOW_EN  when defined, pwm_r/g/b are inverted at the
//                          output register. Their reset/inactive level
//                          becomes 1, for sink-driven LED pins.
// ---------------------------------------------------------------------------
module rgb_pwm #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                duty_valid,
    output logic                duty_ready,
    input  logic [PWM_BITS-1:0] duty_r,
    input  logic [PWM_BITS-1:0] duty_g,
    input  logic [PWM_BITS-1:0] duty_b,
    output logic                period_start,
    output logic                pwm_r,
    output logic                pwm_g,
    output logic                pwm_b
);

    // A prescaler of 1 still needs a one-bit register that simply stays at 0.
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);

`ifdef RGB_PWM_ACTIVE_LOW_EN
    localparam logic OUT_INV = 1'b1;
`else
    localparam logic OUT_INV = 1'b0;
`endif

    logic [PRE_W-1:0]    pre;
    logic [PWM_BITS-1:0] cnt;
    logic                tick;
    logic                boundary;
    logic                transfer;
    logic                rst_q;

    logic                pend_full;
    logic [PWM_BITS-1:0] pend_r;
    logic [PWM_BITS-1:0] pend_g;
    logic [PWM_BITS-1:0] pend_b;
    logic [PWM_BITS-1:0] act_r;
    logic [PWM_BITS-1:0] act_g;
    logic [PWM_BITS-1:0] act_b;

    assign tick     = (pre == PRE_MAX);
    assign boundary = tick && (cnt == '1);

    // rst_q holds ready low for the first clock after reset is released.
    // This way a triple offered during reset is never taken on the release edge.
    assign duty_ready = !pend_full && !rst_q;
    assign transfer   = duty_valid && duty_ready;

    // Registered copy of reset, used only to delay duty_ready after release.
    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    // Prescaler: one tick every PRESCALE clocks.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
        end else if (tick) begin
            pre <= '0;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // PWM count advances once per tick and wraps naturally at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= cnt + PWM_BITS'(1);
        end
    end

    // Pending buffer and active duties. A transfer can only occur while the
    // buffer is empty, so it never collides with the boundary copy. A triple
    // accepted on a boundary cycle therefore waits for the following boundary.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_full <= 1'b0;
            pend_r    <= '0;
            pend_g    <= '0;
            pend_b    <= '0;
            act_r     <= '0;
            act_g     <= '0;
            act_b     <= '0;
        end else begin
            if (transfer) begin
                pend_r    <= duty_r;
                pend_g    <= duty_g;
                pend_b    <= duty_b;
                pend_full <= 1'b1;
            end else if (boundary && pend_full) begin
                act_r     <= pend_r;
                act_g     <= pend_g;
                act_b     <= pend_b;
                pend_full <= 1'b0;
            end
        end
    end

    // Output stage: the compare result is registered. The first cycle of a
    // period still shows the last count of the previous period with the old duty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_r        <= OUT_INV;
            pwm_g        <= OUT_INV;
            pwm_b        <= OUT_INV;
            period_start <= 1'b0;
        end else begin
            pwm_r        <= (cnt < act_r) ^ OUT_INV;
            pwm_g        <= (cnt < act_g) ^ OUT_INV;
            pwm_b        <= (cnt < act_b) ^ OUT_INV;
            period_start <= boundary;
        end
    end

endmodule

// File: tb/tb_rgb_pwm.sv
// ---------------------------------------------------------------------------
// tb_rgb_pwm
//
// Self-checking bench for rgb_pwm. The main instance uses PWM_BITS=8 and
// PRESCALE=1, so one period is 256 clocks. A second instance uses PWM_BITS=4
// and PRESCALE=3, which exercises the prescaler.
//
// Expected per-period high counts are queued when a triple is driven. They
// are popped when a measured period completes. Counts are taken on the
// active level, so the same expectations hold with RGB_PWM_ACTIVE_LOW_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rgb_pwm;

    localparam int PLEN   = 256;
    localparam int PLEN2  = 48;
    localparam int BUDGET = 600;

`ifdef RGB_PWM_ACTIVE_LOW_EN
    localparam logic INACT = 1'b1;
`else
    localparam logic INACT = 1'b0;
`endif

    typedef struct {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         er;
        int         eg;
        int         eb;
    } vec_t;

    typedef struct {
        int r;
        int g;
        int b;
    } exp_t;

    logic       clk          = 1'b0;
    logic       rst          = 1'b1;
    logic       duty_valid   = 1'b0;
    logic       duty_ready;
    logic [7:0] duty_r       = '0;
    logic [7:0] duty_g       = '0;
    logic [7:0] duty_b       = '0;
    logic       period_start;
    logic       pwm_r;
    logic       pwm_g;
    logic       pwm_b;

    logic       rst2         = 1'b1;
    logic       duty2_valid  = 1'b1;
    logic       duty2_ready;
    logic [3:0] duty2_r      = 4'd5;
    logic [3:0] duty2_g      = 4'd0;
    logic [3:0] duty2_b      = 4'd15;
    logic       period_start2;
    logic       pwm2_r;
    logic       pwm2_g;
    logic       pwm2_b;

    int   total = 0;
    int   bad   = 0;
    int   hi_r;
    int   hi_g;
    int   hi_b;
    exp_t sb[$];
    vec_t vecs[4];

    rgb_pwm #(.PWM_BITS(8), .PRESCALE(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .duty_valid   (duty_valid),
        .duty_ready   (duty_ready),
        .duty_r       (duty_r),
        .duty_g       (duty_g),
        .duty_b       (duty_b),
        .period_start (period_start),
        .pwm_r        (pwm_r),
        .pwm_g        (pwm_g),
        .pwm_b        (pwm_b)
    );

    rgb_pwm #(.PWM_BITS(4), .PRESCALE(3)) dut2 (
        .clk          (clk),
        .rst          (rst2),
        .duty_valid   (duty2_valid),
        .duty_ready   (duty2_ready),
        .duty_r       (duty2_r),
        .duty_g       (duty2_g),
        .duty_b       (duty2_b),
        .period_start (period_start2),
        .pwm_r        (pwm2_r),
        .pwm_g        (pwm2_g),
        .pwm_b        (pwm2_b)
    );

    always #5 clk = ~clk;

    // Sampling and driving both happen on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check1(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timeout got 0 expected 1", name);
    endtask

    function automatic vec_t mk_vec(input int r, input int g, input int b);
        vec_t v;
        v.r  = 8'(r);
        v.g  = 8'(g);
        v.b  = 8'(b);
        v.er = r;
        v.eg = g;
        v.eb = b;
        return v;
    endfunction

    function automatic exp_t mk_exp(input int r, input int g, input int b);
        exp_t e;
        e.r = r;
        e.g = g;
        e.b = b;
        return e;
    endfunction

    task automatic clear_counts();
        hi_r = 0;
        hi_g = 0;
        hi_b = 0;
    endtask

    task automatic sample_counts();
        hi_r += int'(pwm_r ^ INACT);
        hi_g += int'(pwm_g ^ INACT);
        hi_b += int'(pwm_b ^ INACT);
    endtask

    task automatic sample_counts2();
        hi_r += int'(pwm2_r ^ INACT);
        hi_g += int'(pwm2_g ^ INACT);
        hi_b += int'(pwm2_b ^ INACT);
    endtask

    task automatic check_reset_state(input string name);
        check1({name, "_pwm_r"}, pwm_r, INACT);
        check1({name, "_pwm_g"}, pwm_g, INACT);
        check1({name, "_pwm_b"}, pwm_b, INACT);
        check1({name, "_pstart"}, period_start, 0);
        check1({name, "_ready"}, duty_ready, 0);
    endtask

    task automatic waitStart(input string name);
        int n = 0;
        while (period_start !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        if (period_start !== 1'b1) fail_timeout(name);
    endtask

    // Counts active cycles over the 256 cycles after a period_start cycle.
    // The last sample lands on the next period_start cycle.
    task automatic countWindow();
        clear_counts();
        for (int i = 0; i < PLEN; i++) begin
            step();
            if (i == 0) duty_valid = 1'b0;
            sample_counts();
        end
    endtask

    task automatic popCompare(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            fail_timeout({name, "_scoreboard_empty"});
            return;
        end
        e = sb.pop_front();
        check1({name, "_r"}, hi_r, e.r);
        check1({name, "_g"}, hi_g, e.g);
        check1({name, "_b"}, hi_b, e.b);
    endtask

    task automatic applyStimulus(input vec_t v);
        int n = 0;
        duty_r     = v.r;
        duty_g     = v.g;
        duty_b     = v.b;
        duty_valid = 1'b1;
        while (duty_ready !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        if (duty_ready !== 1'b1) fail_timeout("apply_ready");
        step();
        duty_valid = 1'b0;
        sb.push_back(mk_exp(v.er, v.eg, v.eb));
    endtask

    // Skip the first period after the transfer; it may still carry the old duty.
    task automatic checkOutput(input string name);
        waitStart({name, "_first"});
        step();
        waitStart({name, "_second"});
        countWindow();
        popCompare(name);
        check1({name, "_spacing"}, period_start, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;

        vecs[0] = mk_vec(64, 0, 255);
        vecs[1] = mk_vec(1, 128, 254);
        vecs[2] = mk_vec(255, 255, 0);
        vecs[3] = mk_vec(0, 200, 1);

        // Reset held three clocks while a triple is offered.
        duty_r     = 8'd77;
        duty_g     = 8'd77;
        duty_b     = 8'd77;
        duty_valid = 1'b1;
        rst        = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_reset_state($sformatf("rst_hold%0d", i));
        end
        rst = 1'b0;
        #1;
        check1("rst_ready_not_early", duty_ready, 0);
        step();
        check1("rst_ready_rise", duty_ready, 1);
        duty_valid = 1'b0;
        sb.push_back(mk_exp(0, 0, 0));
        repeat (3) step();
        check1("rst_no_transfer", duty_ready, 1);
        waitStart("rst_period");
        countWindow();
        popCompare("rst_period");

        // Table-driven duty values.
        foreach (vecs[k]) begin
            applyStimulus(vecs[k]);
            checkOutput($sformatf("vec%0d", k));
        end

        // Backpressure: A accepted, B waits for the boundary that applies A.
        duty_r     = 8'd10;
        duty_g     = 8'd10;
        duty_b     = 8'd10;
        duty_valid = 1'b1;
        n = 0;
        while (duty_ready !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        if (duty_ready !== 1'b1) fail_timeout("bp_a_ready");
        step();
        sb.push_back(mk_exp(10, 10, 10));
        duty_r = 8'd200;
        duty_g = 8'd0;
        duty_b = 8'd0;
        sb.push_back(mk_exp(200, 0, 0));
        check1("bp_ready_low", duty_ready, 0);
        n = 0;
        while (duty_ready !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        if (duty_ready !== 1'b1) fail_timeout("bp_b_ready");
        check1("bp_ready_at_boundary", period_start, 1);
        countWindow();
        popCompare("bp_A");
        check1("bp_spacing", period_start, 1);
        countWindow();
        popCompare("bp_B");

        // Mid-period update: act=100, write 20 while cnt=50.
        applyStimulus(mk_vec(100, 100, 100));
        checkOutput("mid_pre");
        sb.push_back(mk_exp(100, 100, 100));
        clear_counts();
        for (int i = 1; i <= PLEN; i++) begin
            step();
            sample_counts();
            if (i == 50) begin
                check1("mid_ready", duty_ready, 1);
                duty_r     = 8'd20;
                duty_g     = 8'd20;
                duty_b     = 8'd20;
                duty_valid = 1'b1;
                sb.push_back(mk_exp(20, 20, 20));
            end else if (i == 51) begin
                duty_valid = 1'b0;
            end
        end
        popCompare("mid_keep");
        check1("mid_spacing", period_start, 1);
        countWindow();
        popCompare("mid_new");

        // Reset at cnt=128 with a pending triple that must never appear.
        repeat (100) step();
        duty_r     = 8'd250;
        duty_g     = 8'd250;
        duty_b     = 8'd250;
        duty_valid = 1'b1;
        check1("rm_ready", duty_ready, 1);
        step();
        duty_valid = 1'b0;
        check1("rm_pending", duty_ready, 0);
        repeat (27) step();
        rst = 1'b1;
        step();
        check_reset_state("rm_rst0");
        step();
        check_reset_state("rm_rst1");
        rst = 1'b0;
        sb.push_back(mk_exp(0, 0, 0));
        sb.push_back(mk_exp(0, 0, 0));
        clear_counts();
        for (int i = 1; i <= PLEN; i++) begin
            step();
            sample_counts();
            if (i == 1) check1("rm_ready_after", duty_ready, 1);
        end
        popCompare("rm_first");
        check1("rm_restart", period_start, 1);
        countWindow();
        popCompare("rm_second");
        check1("rm_no_pending", duty_ready, 1);

        // Prescaled instance: 16 counts x 3 clocks = 48-clock period.
        check1("p3_rst_pwm_r", pwm2_r, INACT);
        check1("p3_rst_ready", duty2_ready, 0);
        rst2 = 1'b0;
        sb.push_back(mk_exp(15, 0, 45));
        n = 0;
        while (period_start2 !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        if (period_start2 !== 1'b1) fail_timeout("p3_first");
        step();
        n = 0;
        while (period_start2 !== 1'b1 && n < BUDGET) begin
            step();
            n++;
        end
        if (period_start2 !== 1'b1) fail_timeout("p3_second");
        clear_counts();
        for (int i = 0; i < PLEN2; i++) begin
            step();
            sample_counts2();
        end
        popCompare("p3_duty");
        check1("p3_spacing", period_start2, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
